// File: rtl/wb_sram_responder_pkg.sv
// Shared bus widths, FSM state encoding and byte-lane helper for the
// Wishbone SRAM responder.
package wb_sram_responder_pkg;

    localparam int WB_DATA_W   = 16;
    localparam int WB_ADDR_W   = 24;
    localparam int WB_SEL_BITS = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Expand a byte-lane select into a full data-width mask.
    function automatic logic [WB_DATA_W-1:0] lane_mask(input logic [WB_SEL_BITS-1:0] sel);
        return {{8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/wb_sram_array.sv
// Single-port synchronous word memory with per-byte write enables and a
// registered read port.
module wb_sram_array
    import wb_sram_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic                   we,
    input  logic [WB_SEL_BITS-1:0] be,
    input  logic [DEPTH_LOG2-1:0]  addr,
    input  logic [WB_DATA_W-1:0]   wdata,
    output logic [WB_DATA_W-1:0]   rdata
);

    logic [WB_DATA_W-1:0] mem [2**DEPTH_LOG2];

    // NOTE: no reset on the array or its read register, so it maps onto a RAM macro.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < WB_SEL_BITS; i++) begin
                    if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/wb_sram_responder.sv
// Wishbone classic-cycle responder: decodes a word window, inserts wait
// states, terminates with ack or err and fronts a byte-writable SRAM.
module wb_sram_responder
    import wb_sram_responder_pkg::*;
#(
    parameter logic [WB_ADDR_W-1:0] ADDR_BASE   = 24'h000000,
    parameter int                   DEPTH_LOG2  = 10,
    parameter int                   WAIT_CYCLES = 1,
    parameter int                   RO_WORDS    = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   wb_cyc,
    input  logic                   wb_stb,
    input  logic                   wb_we,
    input  logic [WB_ADDR_W-1:0]   wb_adr,
    input  logic [WB_DATA_W-1:0]   wb_i_dat,
    input  logic [WB_SEL_BITS-1:0] wb_sel,
    output logic [WB_DATA_W-1:0]   wb_o_dat,
    output logic                   wb_ack,
    output logic                   wb_err,
    output logic                   wb_rty
);

    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [1:0]             state;
    logic [3:0]             wait_cnt;
    logic                   ack_q, err_q;
    logic                   we_q;
    logic [DEPTH_LOG2-1:0]  off_q;
    logic [WB_DATA_W-1:0]   dat_q;
    logic [WB_SEL_BITS-1:0] sel_q;

    logic                   req, hit, ro_hit, bad;
    logic [DEPTH_LOG2-1:0]  off;

    logic                   mem_en, mem_we;
    logic [WB_SEL_BITS-1:0] mem_be;
    logic [DEPTH_LOG2-1:0]  mem_addr;
    logic [WB_DATA_W-1:0]   mem_wdata, rd_data;

    assign req = wb_cyc & wb_stb;
    assign hit = (wb_adr[WB_ADDR_W-1:DEPTH_LOG2] == ADDR_BASE[WB_ADDR_W-1:DEPTH_LOG2]);
    assign off = wb_adr[DEPTH_LOG2-1:0];

    generate
        if (RO_WORDS == 0) begin : g_no_ro
            assign ro_hit = 1'b0;
        end else begin : g_ro
            localparam logic [DEPTH_LOG2:0] RO_LIM = RO_WORDS[DEPTH_LOG2:0];
            assign ro_hit = ({1'b0, off} < RO_LIM);
        end
    endgenerate

    assign bad = !hit || (wb_we && ro_hit);

    // The array is accessed on the edge that enters RESP: straight from the
    // bus when there are no wait states, otherwise from the latched request.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = we_q;
        mem_be    = sel_q;
        mem_addr  = off_q;
        mem_wdata = dat_q;
        if (state == ST_IDLE) begin
            mem_we    = wb_we;
            mem_be    = wb_sel;
            mem_addr  = off;
            mem_wdata = wb_i_dat;
        end
        if (!i_rst) begin
            case (state)
                ST_IDLE: mem_en = NO_WAIT && req && !bad;
                ST_WAIT: mem_en = req && (wait_cnt == 4'd0);
                default: mem_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (bad) begin
                            state <= ST_RESP;
                            err_q <= 1'b1;
                        end else if (NO_WAIT) begin
                            state <= ST_RESP;
                            ack_q <= 1'b1;
                        end else begin
                            wait_cnt <= WAIT_LOAD;
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state <= ST_RESP;
                        ack_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: request payload flops need no reset; they are only consumed after IDLE captures them.
    always_ff @(posedge i_clk) begin
        if (state == ST_IDLE && req) begin
            we_q  <= wb_we;
            off_q <= off;
            dat_q <= wb_i_dat;
            sel_q <= wb_sel;
        end
    end

    wb_sram_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk   (i_clk),
        .en    (mem_en),
        .we    (mem_we),
        .be    (mem_be),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (rd_data)
    );

    // Read data is only driven during a read ack; everything here is register-sourced.
    assign wb_o_dat = (ack_q && !we_q) ? (rd_data & lane_mask(sel_q)) : '0;
    assign wb_ack   = ack_q;
    assign wb_err   = err_q;
    assign wb_rty   = 1'b0;

endmodule
